// File: rtl/seg_shift_out.sv
// Serial segment-map transmitter for a shift/storage-register display chain.
// One frame: WIDTH bits MSB-first on s_data/s_clk, then an s_latch strobe.
module seg_shift_out #(
  parameter int DIV   = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] P_Data,
  output logic             s_clk,
  output logic             s_data,
  output logic             s_clrn,
  output logic             s_latch,
  output logic             busy,
  output logic             done
);

  localparam int DW = $clog2(DIV + 1);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t           state_q;
  logic [WIDTH-2:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    div_q;
  logic             sclk_q;
  logic             sdata_q;
  logic             clrn_q;
  logic             latch_q;
  logic             busy_q;
  logic             done_q;

  logic div_end;
  logic last_bit;

  assign div_end  = (div_q == DW'(DIV - 1));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // sr_q holds the bits still to come; the current bit lives in sdata_q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      clrn_q  <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clrn_q <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= P_Data[WIDTH-2:0];
            sdata_q <= P_Data[WIDTH-1];
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (last_bit) begin
                sdata_q <= 1'b0;
                latch_q <= 1'b1;
                state_q <= LATCH;
              end else begin
                sdata_q <= sr_q[WIDTH-2];
                sr_q    <= sr_q << 1;
                cnt_q   <= cnt_q + 1'b1;
              end
            end
          end
        end
        LATCH: begin
          if (!div_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q   <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_clk   = sclk_q;
  assign s_data  = sdata_q;
  assign s_clrn  = clrn_q;
  assign s_latch = latch_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seg_shift_out.sv
// Bench for seg_shift_out: DIV=2 and DIV=1 instances, bit scoreboards
// filled at frame start and drained on observed s_clk rises.
module tb_seg_shift_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst_a_n, start_a;
  logic [63:0] pdata_a;
  logic        sclk_a, sdata_a, sclrn_a, slatch_a, busy_a, done_a;

  logic        rst_b_n, start_b;
  logic [63:0] pdata_b;
  logic        sclk_b, sdata_b, sclrn_b, slatch_b, busy_b, done_b;

  seg_shift_out #(.DIV(2), .WIDTH(64)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_a_n),
    .start  (start_a),
    .P_Data (pdata_a),
    .s_clk  (sclk_a),
    .s_data (sdata_a),
    .s_clrn (sclrn_a),
    .s_latch(slatch_a),
    .busy   (busy_a),
    .done   (done_a)
  );

  seg_shift_out #(.DIV(1), .WIDTH(64)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_b_n),
    .start  (start_b),
    .P_Data (pdata_b),
    .s_clk  (sclk_b),
    .s_data (sdata_b),
    .s_clrn (sclrn_b),
    .s_latch(slatch_b),
    .busy   (busy_b),
    .done   (done_b)
  );

  bit          q_a[$];
  bit          q_b[$];
  int          rises_a = 0;
  int          rises_b = 0;
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;
  logic [63:0] cap_b = '0;

  always @(negedge clk) begin
    bit e;
    if (sclk_a === 1'b1 && prev_a === 1'b0) begin
      rises_a++;
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL rise_a unexpected s_clk rise: s_data=%b required no rise",
                 sdata_a);
      end else begin
        e = q_a.pop_front();
        if (sdata_a !== e) begin
          failures++;
          $display("FAIL rise_a bit %0d: s_data=%b required %b",
                   rises_a, sdata_a, e);
        end
      end
    end
    prev_a = sclk_a;
  end

  always @(negedge clk) begin
    bit e;
    if (sclk_b === 1'b1 && prev_b === 1'b0) begin
      rises_b++;
      cap_b = {cap_b[62:0], sdata_b};
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL rise_b unexpected s_clk rise: s_data=%b required no rise",
                 sdata_b);
      end else begin
        e = q_b.pop_front();
        if (sdata_b !== e) begin
          failures++;
          $display("FAIL rise_b bit %0d: s_data=%b required %b",
                   rises_b, sdata_b, e);
        end
      end
    end
    prev_b = sclk_b;
  end

  task automatic push_a(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) q_a.push_back(d[i]);
  endtask

  task automatic push_b(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) q_b.push_back(d[i]);
  endtask

  // Called #1 after the accept edge; returns cycles to done, or -1 on timeout
  task automatic wait_done_a(output int n, output int lat, output int bsy);
    n   = 0;
    lat = 0;
    bsy = busy_a ? 1 : 0;
    while (!done_a && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (slatch_a) lat++;
      if (busy_a) bsy++;
    end
    if (!done_a) n = -1;
  endtask

  task automatic wait_done_b(output int n, output int tog_err,
                             output int one_err);
    n       = 0;
    tog_err = 0;
    one_err = 0;
    if (sclk_b !== 1'b0) tog_err++;
    if (sdata_b !== 1'b1) one_err++;
    while (!done_b && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n < 128) begin
        if (sclk_b !== n[0]) tog_err++;
        if (sdata_b !== 1'b1) one_err++;
      end
    end
    if (!done_b) n = -1;
  endtask

  task automatic test_reset;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b1; start_b = 1'b1;
    pdata_a = '1;   pdata_b = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sclrn_a, sclk_a, sdata_a, slatch_a, busy_a, done_a} !== 6'b0) begin
      failures++;
      $display("FAIL reset_a outputs=%b required 000000",
               {sclrn_a, sclk_a, sdata_a, slatch_a, busy_a, done_a});
    end
    checks++;
    if ({sclrn_b, sclk_b, sdata_b, slatch_b, busy_b, done_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_b outputs=%b required 000000",
               {sclrn_b, sclk_b, sdata_b, slatch_b, busy_b, done_b});
    end
    start_a = 1'b0; start_b = 1'b0;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sclrn_a, sclk_a, sdata_a, slatch_a, busy_a, done_a} !== 6'b100000) begin
      failures++;
      $display("FAIL release_a outputs=%b required 100000",
               {sclrn_a, sclk_a, sdata_a, slatch_a, busy_a, done_a});
    end
    checks++;
    if ({sclrn_b, sclk_b, sdata_b, slatch_b, busy_b, done_b} !== 6'b100000) begin
      failures++;
      $display("FAIL release_b outputs=%b required 100000",
               {sclrn_b, sclk_b, sdata_b, slatch_b, busy_b, done_b});
    end
  endtask

  task automatic test_single_frame;
    int n, lat, bsy;
    pdata_a = 64'h8000_0000_0000_0001;
    push_a(pdata_a);
    rises_a = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++;
    if ({busy_a, sclk_a, sdata_a} !== 3'b101) begin
      failures++;
      $display("FAIL single_accept busy/sclk/sdata=%b required 101",
               {busy_a, sclk_a, sdata_a});
    end
    wait_done_a(n, lat, bsy);
    checks++;
    if (n != 258) begin
      failures++;
      $display("FAIL single_len cycles=%0d required 258", n);
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL single_latch cycles=%0d required 2", lat);
    end
    checks++;
    if (bsy != 258) begin
      failures++;
      $display("FAIL single_busy cycles=%0d required 258", bsy);
    end
    checks++;
    if (rises_a != 64 || q_a.size() != 0) begin
      failures++;
      $display("FAIL single_rises rises=%0d left=%0d required 64/0",
               rises_a, q_a.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_protect;
    logic [63:0] d0;
    int n, bz;
    d0 = 64'hC3C3_1234_5678_9ABC;
    pdata_a = d0;
    push_a(d0);
    rises_a = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    n  = 0;
    bz = 0;
    while (!done_a && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) pdata_a = ~d0;
      if (n == 100) pdata_a = d0 ^ 64'hFFFF_0000_FFFF_0000;
      if (n == 200) start_a = 1'b0;
      if (!busy_a && !done_a) bz++;
    end
    checks++;
    if (n != 258) begin
      failures++;
      $display("FAIL protect_len cycles=%0d required 258", n);
    end
    checks++;
    if (bz != 0) begin
      failures++;
      $display("FAIL protect_busy idle_cycles=%0d required 0", bz);
    end
    checks++;
    if (rises_a != 64 || q_a.size() != 0) begin
      failures++;
      $display("FAIL protect_rises rises=%0d left=%0d required 64/0",
               rises_a, q_a.size());
    end
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL protect_idle busy=%b required 0", busy_a);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] x, y;
    int n, lat, bsy;
    x = 64'h0123_4567_89AB_CDEF;
    y = 64'hFEDC_BA98_7654_3210;
    pdata_a = x;
    push_a(x);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a(n, lat, bsy);
    checks++;
    if (n != 258) begin
      failures++;
      $display("FAIL b2b_first_len cycles=%0d required 258", n);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap busy=%b required 0", busy_a);
    end
    pdata_a = y;
    push_a(y);
    rises_a = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++;
    if ({busy_a, sclk_a, sdata_a} !== {1'b1, 1'b0, y[63]}) begin
      failures++;
      $display("FAIL b2b_accept busy/sclk/sdata=%b required %b",
               {busy_a, sclk_a, sdata_a}, {1'b1, 1'b0, y[63]});
    end
    wait_done_a(n, lat, bsy);
    checks++;
    if (n != 258 || rises_a != 64) begin
      failures++;
      $display("FAIL b2b_second cycles=%0d rises=%0d required 258/64",
               n, rises_a);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset;
    int n, lat_cnt, done_cnt;
    pdata_a = 64'hFFFF_FFFF_FFFF_FFFF;
    push_a(pdata_a);
    rises_a = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (rises_a < 10 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rises_a != 10) begin
      failures++;
      $display("FAIL midrst_reach rises=%0d required 10", rises_a);
    end
    rst_a_n = 1'b0;
    @(posedge clk); #1;
    q_a.delete();
    checks++;
    if ({sclrn_a, sclk_a, busy_a, slatch_a, done_a} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_abort clrn/sclk/busy/latch/done=%b required 00000",
               {sclrn_a, sclk_a, busy_a, slatch_a, done_a});
    end
    rst_a_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sclrn_a !== 1'b1) begin
      failures++;
      $display("FAIL midrst_clrn s_clrn=%b required 1", sclrn_a);
    end
    lat_cnt  = 0;
    done_cnt = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (slatch_a) lat_cnt++;
      if (done_a) done_cnt++;
    end
    checks++;
    if (lat_cnt != 0 || done_cnt != 0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet latch=%0d done=%0d busy=%b required 0/0/0",
               lat_cnt, done_cnt, busy_a);
    end
  endtask

  task automatic test_pattern;
    logic [63:0] d;
    int n, te, oe;
    d = 64'hA5A5_0F0F_3C3C_FF00;
    pdata_b = d;
    push_b(d);
    rises_b = 0;
    cap_b   = '0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_done_b(n, te, oe);
    checks++;
    if (cap_b !== d) begin
      failures++;
      $display("FAIL pattern_capture got=%h required %h", cap_b, d);
    end
    checks++;
    if (n != 129 || rises_b != 64) begin
      failures++;
      $display("FAIL pattern_len cycles=%0d rises=%0d required 129/64",
               n, rises_b);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_min_div;
    int n, te, oe;
    pdata_b = '1;
    push_b(pdata_b);
    rises_b = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    wait_done_b(n, te, oe);
    checks++;
    if (n != 129) begin
      failures++;
      $display("FAIL mindiv_len cycles=%0d required 129", n);
    end
    checks++;
    if (te != 0 || oe != 0) begin
      failures++;
      $display("FAIL mindiv_wave toggle_err=%0d data_err=%0d required 0/0",
               te, oe);
    end
    checks++;
    if (rises_b != 64 || q_b.size() != 0) begin
      failures++;
      $display("FAIL mindiv_rises rises=%0d left=%0d required 64/0",
               rises_b, q_b.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_busy_protect();
    test_back_to_back();
    test_mid_reset();
    test_pattern();
    test_min_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
